// File: rtl/if_id_stage.sv
// ============================================================================
// Module : if_id_stage
// Brief  : Fetch stage and IF/ID pipeline register with branch redirect,
//          stall hold, halt detection and a saturating stall-cycle counter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module if_id_stage #(
    parameter int                  PC_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [31:0]         NOP_INSTR  = 32'h0000_0000,
    parameter logic [31:0]         HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_rdata,
    output logic                id_valid,
    output logic [31:0]         id_instr,
    output logic [PC_WIDTH-1:0] id_pc,
    output logic [PC_WIDTH-1:0] id_pc_plus4,
    output logic [4:0]          rs,
    output logic [4:0]          rt,
    output logic [4:0]          rd,
    output logic                halted,
    output logic [15:0]         stall_cycles
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t              state_q,       state_d;
    logic [PC_WIDTH-1:0] pc_q,          pc_d;
    logic                id_valid_q,    id_valid_d;
    logic [31:0]         id_instr_q,    id_instr_d;
    logic [PC_WIDTH-1:0] id_pc_q,       id_pc_d;
    logic [PC_WIDTH-1:0] id_pc_plus4_q, id_pc_plus4_d;
    logic                halted_q,      halted_d;
    logic [15:0]         stall_cnt_q,   stall_cnt_d;

    logic [PC_WIDTH-1:0] pc_plus4;
    logic                halt_in_id;

    assign pc_plus4   = pc_q + PC_WIDTH'(4);
    assign halt_in_id = id_valid_q && (id_instr_q == HALT_INSTR);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        id_valid_d    = id_valid_q;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        halted_d      = halted_q;
        stall_cnt_d   = stall_cnt_q;

        if (state_q == ST_HALTED) begin
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
            halted_d   = 1'b1;
        end else if (branch_taken) begin
            // Branch beats stall: the instruction in ID is on the wrong path.
            pc_d       = branch_target;
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
        end else if (stall) begin
            if (stall_cnt_q != 16'hFFFF) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end else if (halt_in_id) begin
            state_d    = ST_HALTED;
            halted_d   = 1'b1;
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
        end else begin
            pc_d          = pc_plus4;
            id_valid_d    = 1'b1;
            id_instr_d    = imem_rdata;
            id_pc_d       = pc_q;
            id_pc_plus4_d = pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            id_valid_q    <= 1'b0;
            id_instr_q    <= NOP_INSTR;
            id_pc_q       <= '0;
            id_pc_plus4_q <= '0;
            halted_q      <= 1'b0;
            stall_cnt_q   <= 16'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            halted_q      <= halted_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign imem_addr    = pc_q;
    assign id_valid     = id_valid_q;
    assign id_instr     = id_instr_q;
    assign id_pc        = id_pc_q;
    assign id_pc_plus4  = id_pc_plus4_q;
    assign halted       = halted_q;
    assign stall_cycles = stall_cnt_q;

    // Bubbles present register 0 so the stall unit never sees a false hazard.
    assign rs = id_valid_q ? id_instr_q[25:21] : 5'd0;
    assign rt = id_valid_q ? id_instr_q[20:16] : 5'd0;
    assign rd = id_valid_q ? id_instr_q[15:11] : 5'd0;

endmodule

`default_nettype wire

// File: tb/tb_if_id_stage.sv
// ============================================================================
// Module : tb_if_id_stage
// Brief  : Directed scenarios plus randomized run against a behavioural model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_if_id_stage;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [4:0]  rs, rt, rd;
    logic        halted;
    logic [15:0] stall_cycles;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem [0:255];

    // Model state
    logic [31:0] m_pc, m_instr, m_idpc;
    logic        m_valid, m_halted;
    logic [15:0] m_cnt;

    if_id_stage dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .id_valid     (id_valid),
        .id_instr     (id_instr),
        .id_pc        (id_pc),
        .id_pc_plus4  (id_pc_plus4),
        .rs           (rs),
        .rt           (rt),
        .rd           (rd),
        .halted       (halted),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    // Low 1 KiB backed by mem[]; elsewhere an address-derived word with MSB 0.
    assign imem_rdata = (imem_addr < 32'd1024) ? mem[imem_addr[9:2]]
                                               : {1'b0, imem_addr[30:0] ^ 31'h1234_5678};

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        if (a < 32'd1024) return mem[a[9:2]];
        return {1'b0, a[30:0] ^ 31'h1234_5678};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = $urandom & 32'h7FFF_FFFF;
    endtask

    task automatic do_reset();
        stall = 1'b0;
        branch_taken = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b0;
        tick();
        if ({imem_addr, id_valid, id_instr, id_pc, id_pc_plus4, rs, rt, rd, halted, stall_cycles}
            !== {32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 15'h0, 1'b0, 16'h0}) begin
            miscompares++;
            $display("FAIL reset_state: got addr=%h v=%b instr=%h idpc=%h p4=%h h=%b cnt=%h",
                     imem_addr, id_valid, id_instr, id_pc, id_pc_plus4, halted, stall_cycles);
        end
        vectors++;
        reset = 1'b1;
    endtask

    task automatic test_straight_line();
        logic [31:0] exp_i [0:1];
        exp_i[0] = 32'h11;
        exp_i[1] = 32'h22;
        for (int k = 0; k < 2; k++) begin
            tick();
            if ({id_valid, id_instr, id_pc, id_pc_plus4, imem_addr}
                !== {1'b1, exp_i[k], 32'(k * 4), 32'(k * 4 + 4), 32'(k * 4 + 4)}) begin
                miscompares++;
                $display("FAIL fetch_%0d: got v=%b instr=%h pc=%h p4=%h addr=%h want instr=%h pc=%h",
                         k, id_valid, id_instr, id_pc, id_pc_plus4, imem_addr, exp_i[k], k * 4);
            end
            vectors++;
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            if ({imem_addr, id_instr, id_valid, stall_cycles} !== {32'h8, 32'h22, 1'b1, 16'(k)}) begin
                miscompares++;
                $display("FAIL stall_hold_%0d: got addr=%h instr=%h v=%b cnt=%0d want 8/22/1/%0d",
                         k, imem_addr, id_instr, id_valid, stall_cycles, k);
            end
            vectors++;
        end
        stall = 1'b0;
        tick();
        if ({id_instr, id_pc, imem_addr, stall_cycles} !== {32'h33, 32'h8, 32'hC, 16'd3}) begin
            miscompares++;
            $display("FAIL stall_resume: got instr=%h pc=%h addr=%h cnt=%0d want 33/8/c/3",
                     id_instr, id_pc, imem_addr, stall_cycles);
        end
        vectors++;
    endtask

    task automatic test_branch();
        stall = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h40;
        tick();
        stall = 1'b0;
        branch_taken = 1'b0;
        if ({id_valid, rs, rt, imem_addr, stall_cycles} !== {1'b0, 5'd0, 5'd0, 32'h40, 16'd3}) begin
            miscompares++;
            $display("FAIL branch_bubble: got v=%b rs=%0d rt=%0d addr=%h cnt=%0d want 0/0/0/40/3",
                     id_valid, rs, rt, imem_addr, stall_cycles);
        end
        vectors++;
        tick();
        if ({id_valid, id_instr, id_pc} !== {1'b1, mem[16], 32'h40}) begin
            miscompares++;
            $display("FAIL branch_target: got v=%b instr=%h pc=%h want 1/%h/40",
                     id_valid, id_instr, id_pc, mem[16]);
        end
        vectors++;
    endtask

    task automatic test_async_reset();
        stall = 1'b1;
        tick();
        tick();
        stall = 1'b0;
        branch_taken = 1'b1;
        branch_target = 32'h40;
        tick();
        branch_taken = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        if ({imem_addr, id_valid, id_instr, id_pc, id_pc_plus4, rs, rt, rd, halted, stall_cycles}
            !== {32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 15'h0, 1'b0, 16'h0}) begin
            miscompares++;
            $display("FAIL async_reset: got addr=%h v=%b instr=%h cnt=%0d want all zero",
                     imem_addr, id_valid, id_instr, stall_cycles);
        end
        vectors++;
        #2;
        reset = 1'b1;
        tick();
        if ({id_valid, id_instr, id_pc} !== {1'b1, 32'h11, 32'h0}) begin
            miscompares++;
            $display("FAIL post_reset_fetch: got v=%b instr=%h pc=%h want 1/11/0",
                     id_valid, id_instr, id_pc);
        end
        vectors++;
    endtask

    task automatic test_halt();
        mem[3] = HALT;
        do_reset();
        repeat (4) tick();
        if ({id_instr, id_valid, halted, imem_addr} !== {HALT, 1'b1, 1'b0, 32'h10}) begin
            miscompares++;
            $display("FAIL halt_in_id: got instr=%h v=%b h=%b addr=%h want ffffffff/1/0/10",
                     id_instr, id_valid, halted, imem_addr);
        end
        vectors++;
        tick();
        if ({halted, id_valid, id_instr, imem_addr} !== {1'b1, 1'b0, 32'h0, 32'h10}) begin
            miscompares++;
            $display("FAIL halt_enter: got h=%b v=%b instr=%h addr=%h want 1/0/0/10",
                     halted, id_valid, id_instr, imem_addr);
        end
        vectors++;
        branch_taken = 1'b1;
        branch_target = 32'h0;
        tick();
        branch_taken = 1'b0;
        stall = 1'b1;
        tick();
        stall = 1'b0;
        tick();
        stall = 1'b1;
        tick();
        stall = 1'b0;
        if ({halted, id_valid, imem_addr, stall_cycles, rs, rt} !== {1'b1, 1'b0, 32'h10, 16'd0, 10'd0}) begin
            miscompares++;
            $display("FAIL halt_sticky: got h=%b v=%b addr=%h cnt=%0d want 1/0/10/0",
                     halted, id_valid, imem_addr, stall_cycles);
        end
        vectors++;
        mem[3] = 32'h33;
    endtask

    task automatic model_step(input logic s, input logic b, input logic [31:0] t);
        if (m_halted) return;
        if (b) begin
            m_pc = t;
            m_valid = 1'b0;
            m_instr = 32'h0;
        end else if (s) begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else if (m_valid && m_instr == HALT) begin
            m_halted = 1'b1;
            m_valid = 1'b0;
            m_instr = 32'h0;
        end else begin
            m_idpc = m_pc;
            m_instr = exp_word(m_pc);
            m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic test_random();
        logic [96:0] got, exp;
        for (int seg = 0; seg < 4; seg++) begin
            fill_mem();
            mem[$urandom_range(8, 255)] = HALT;
            do_reset();
            m_pc = 32'h0; m_instr = 32'h0; m_idpc = 32'h0;
            m_valid = 1'b0; m_halted = 1'b0; m_cnt = 16'h0;
            for (int c = 0; c < 500; c++) begin
                stall = ($urandom_range(0, 9) < 3);
                branch_taken = ($urandom_range(0, 9) == 0);
                branch_target = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0
                                                            : 32'($urandom_range(0, 255)) * 32'd4;
                @(posedge clk);
                model_step(stall, branch_taken, branch_target);
                #1;
                got = {imem_addr, id_valid, id_instr, rs, rt, rd, halted, stall_cycles};
                exp = {m_pc, m_valid, m_instr,
                       m_valid ? m_instr[25:21] : 5'd0,
                       m_valid ? m_instr[20:16] : 5'd0,
                       m_valid ? m_instr[15:11] : 5'd0,
                       m_halted, m_cnt};
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL random_state seg%0d cyc%0d: got %h want %h", seg, c, got, exp);
                end
                vectors++;
                if (m_valid) begin
                    if ({id_pc, id_pc_plus4} !== {m_idpc, m_idpc + 32'd4}) begin
                        miscompares++;
                        $display("FAIL random_idpc seg%0d cyc%0d: got %h/%h want %h",
                                 seg, c, id_pc, id_pc_plus4, m_idpc);
                    end
                    vectors++;
                end
            end
        end
        stall = 1'b0;
        branch_taken = 1'b0;
    endtask

    task automatic test_sat_wrap();
        mem[3] = 32'h33;
        do_reset();
        stall = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        if (stall_cycles !== 16'hFFFE) begin
            miscompares++;
            $display("FAIL sat_before: got %h want fffe", stall_cycles);
        end
        vectors++;
        tick();
        if (stall_cycles !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL sat_reach: got %h want ffff", stall_cycles);
        end
        vectors++;
        repeat (4465) @(posedge clk);
        #1;
        if ({stall_cycles, imem_addr} !== {16'hFFFF, 32'h0}) begin
            miscompares++;
            $display("FAIL sat_hold: got cnt=%h addr=%h want ffff/0", stall_cycles, imem_addr);
        end
        vectors++;
        stall = 1'b0;
        branch_taken = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        tick();
        branch_taken = 1'b0;
        if (imem_addr !== 32'hFFFF_FFFC) begin
            miscompares++;
            $display("FAIL wrap_start: got %h want fffffffc", imem_addr);
        end
        vectors++;
        tick();
        if ({imem_addr, id_pc, id_pc_plus4, id_instr, stall_cycles}
            !== {32'h0, 32'hFFFF_FFFC, 32'h0, exp_word(32'hFFFF_FFFC), 16'hFFFF}) begin
            miscompares++;
            $display("FAIL wrap: got addr=%h pc=%h p4=%h instr=%h cnt=%h want 0/fffffffc/0",
                     imem_addr, id_pc, id_pc_plus4, id_instr, stall_cycles);
        end
        vectors++;
    endtask

    initial begin
        fill_mem();
        mem[0] = 32'h11;
        mem[1] = 32'h22;
        mem[2] = 32'h33;
        test_reset();
        test_straight_line();
        test_stall();
        test_branch();
        test_async_reset();
        test_halt();
        test_sat_wrap();
        mem[0] = 32'h11;
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
